// File: rtl/muldiv_pkg.sv
// Shared constants and types for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  // Absolute value for signed ops; 0x80000000 maps to 2^31 as an unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply, or restoring divide when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  logic            is_div_i,
`endif
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;
`endif

  always_comb begin
    // Multiplier sits in lo and drains out of bit 0 as the product shifts in.
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    hi_o = sum[XLEN:1];
    lo_o = {sum[0], lo_i[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    // Partial remainder in hi, dividend bits shift out of lo while quotient bits shift in.
    rem_sh = {hi_i, lo_i[XLEN-1]};
    ge     = (rem_sh >= {1'b0, opnd_i});
    diff   = rem_sh[XLEN-1:0] - opnd_i;
    if (is_div_i) begin
      hi_o = ge ? diff : rem_sh[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Iterative MIPS-style mul/div unit with HI/LO registers; division is built only with MULDIV_DIV_EN.
module ex_muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush_in,
  output logic            stall_out,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output logic            div_by_zero_out
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              neg_res_q, neg_res_d;
  logic              dbz_q, dbz_d;
`ifdef MULDIV_DIV_EN
  logic              is_div_q, is_div_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dbz_pend_q, dbz_pend_d;
`endif

  logic              in_accept_state, accept, sgn_op;
  logic [XLEN-1:0]   a_mag, b_mag, step_hi, step_lo;
  logic [2*XLEN-1:0] prod_fix;

  assign in_accept_state = (state_q == IDLE) || (state_q == DONE);
  assign accept          = start && in_accept_state && !flush_in;
  assign sgn_op          = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag           = magnitude(src_a, sgn_op);
  assign b_mag           = magnitude(src_b, sgn_op);
  assign prod_fix        = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .is_div_i (is_div_q),
`endif
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    dbz_d     = dbz_q;
`ifdef MULDIV_DIV_EN
    is_div_d   = is_div_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
`endif

    if (flush_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        RUN: begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) state_d = FIX;
        end
        FIX: begin
          state_d      = DONE;
          {hi_d, lo_d} = prod_fix;
`ifdef MULDIV_DIV_EN
          if (is_div_q) begin
            lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
            hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
          end
          dbz_d = dbz_q | dbz_pend_q;
`endif
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase

      // Accepting in DONE overrides the DONE->IDLE default above.
      if (accept) begin
        cnt_d     = '0;
        dbz_d     = 1'b0;
        acc_hi_d  = '0;
        neg_res_d = sgn_op && (src_a[XLEN-1] ^ src_b[XLEN-1]);
        state_d   = RUN;
`ifdef MULDIV_DIV_EN
        is_div_d   = op[1];
        neg_rem_d  = sgn_op && src_a[XLEN-1];
        dbz_pend_d = 1'b0;
        if (op[1] && (src_b == '0)) begin
          // Preloaded so FIX passes the fixed divide-by-zero result straight through.
          acc_hi_d   = src_a;
          acc_lo_d   = '1;
          neg_res_d  = 1'b0;
          neg_rem_d  = 1'b0;
          dbz_pend_d = 1'b1;
          state_d    = FIX;
        end else if (op[1]) begin
          acc_lo_d = a_mag;
          opnd_d   = b_mag;
        end else begin
          acc_lo_d = b_mag;
          opnd_d   = a_mag;
        end
`else
        if (op[1]) begin
          state_d = DONE;
          hi_d    = '0;
          lo_d    = '0;
        end else begin
          acc_lo_d = b_mag;
          opnd_d   = a_mag;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_res_q  <= 1'b0;
      dbz_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q   <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_res_q  <= neg_res_d;
      dbz_q      <= dbz_d;
`ifdef MULDIV_DIV_EN
      is_div_q   <= is_div_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
`endif
    end
  end

  assign stall_out       = (start && in_accept_state) || (state_q == RUN) || (state_q == FIX);
  assign busy_out        = (state_q != IDLE);
  assign done_out        = (state_q == DONE);
  assign hi_out          = hi_q;
  assign lo_out          = lo_q;
  assign div_by_zero_out = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer against an arithmetic reference model.
module tb_ex_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush_in;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall_out, busy_out, done_out, div_by_zero_out;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi = '0, last_lo = '0;
  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};

  always #5 clk = ~clk;

  ex_muldiv_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .src_a           (src_a),
    .src_b           (src_b),
    .flush_in        (flush_in),
    .stall_out       (stall_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .hi_out          (hi_out),
    .lo_out          (lo_out),
    .div_by_zero_out (div_by_zero_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected HI/LO, sticky flag and done cycle straight from the arithmetic definition.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dbz, output int lat);
    logic [63:0] p;
    longint sa, sb;
`ifdef MULDIV_DIV_EN
    longint q, r;
`endif
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    lat = 34;
    hi  = '0;
    lo  = '0;
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = sa * sb;                  hi = p[63:32]; lo = p[31:0]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'h0) begin
          hi = a; lo = 32'hFFFFFFFF; dbz = 1'b1; lat = 2;
        end else if (o == 2'b10) begin
          hi = a % b; lo = a / b;
        end else begin
          q = sa / sb; r = sa % sb;
          hi = r[31:0]; lo = q[31:0];
        end
`else
        lat = 1;
`endif
      end
    endcase
  endfunction

  // Called on a negedge: drives cycle 0, leaves the bench at cycle 1 with garbage on the operands.
  task automatic start_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    chk({tag, "_stall_c0"}, stall_out, 1);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] eh,
                           input logic [31:0] el, input logic ed, input int noise_cyc);
    int lat    = 1;
    int stalls = 1;
    bit seen   = 1'b0;
    while (!seen && lat < 200) begin
      #1;
      if (done_out === 1'b1) seen = 1'b1;
      else begin
        if (stall_out === 1'b1) stalls++;
        if (lat == noise_cyc) begin
          start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        lat++;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_stall_cycles"}, stalls, exp_lat);
    chk({tag, "_hi"}, hi_out, eh);
    chk({tag, "_lo"}, lo_out, el);
    chk({tag, "_dbz"}, div_by_zero_out, ed);
    chk({tag, "_stall_done"}, stall_out, 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int noise_cyc, input bit b2b);
    logic [31:0] eh, el;
    logic        ed;
    int          lat;
    model(o, a, b, eh, el, ed, lat);
    start_op(tag, o, a, b);
    wait_done(tag, lat, eh, el, ed, noise_cyc);
    $display("%s op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dbz=%0b", tag, o, a, b, hi_out, lo_out, div_by_zero_out);
    last_hi = eh;
    last_lo = el;
    if (!b2b) begin
      @(negedge clk); #1;
      chk({tag, "_done_clear"}, done_out, 0);
      chk({tag, "_idle"}, busy_out, 0);
    end
  endtask

  initial begin
    int seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; flush_in = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_hi", hi_out, 0);
    chk("reset_lo", lo_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_done", done_out, 0);
    chk("reset_dbz", div_by_zero_out, 0);
    chk("reset_stall", stall_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    chk("multu_max_hi_const", hi_out, 32'hFFFFFFFE);
    chk("multu_max_lo_const", lo_out, 32'h00000001);
    run_op("mult_m3x7", 2'b01, 32'hFFFFFFFD, 32'd7, 0, 1'b0);
    chk("mult_m3x7_hi_const", hi_out, 32'hFFFFFFFF);
    chk("mult_m3x7_lo_const", lo_out, 32'hFFFFFFEB);
    run_op("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
    run_op("div_wrap", 2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    run_op("divu_by0", 2'b10, 32'd100, 32'd0, 0, 1'b0);

    // Flush mid-MULT: accept clears the sticky flag, flush leaves HI/LO alone.
    start_op("flush", 2'b01, 32'h00001234, 32'hFFFF0001);
    #1;
    chk("flush_dbz_cleared", div_by_zero_out, 0);
    repeat (9) @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    #1;
    chk("flush_idle", busy_out, 0);
    chk("flush_no_done", done_out, 0);
    chk("flush_hi_hold", hi_out, last_hi);
    chk("flush_lo_hold", lo_out, last_lo);
    seen = 0;
    repeat (40) begin @(negedge clk); #1; if (done_out) seen = 1; end
    chk("flush_never_done", seen, 0);
    $display("flush op=1 at cycle 10 -> busy=%0b hi=%08h lo=%08h", busy_out, hi_out, lo_out);

    // Flush wins over a simultaneous start.
    @(negedge clk);
    start = 1'b1; flush_in = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    start = 1'b0; flush_in = 1'b0;
    #1;
    chk("flush_prio_idle", busy_out, 0);
    $display("flush+start same cycle -> busy=%0b", busy_out);

    // Back-to-back with a stray start during RUN.
    @(negedge clk);
    run_op("b2b_first", 2'b00, $urandom, $urandom, 5, 1'b1);
    run_op("b2b_second", 2'b01, $urandom, $urandom, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_op($sformatf("rand%0d", i), ro, ra, rb, 0, ($urandom_range(0, 1) == 1));
    end
    @(negedge clk);

    // Asynchronous reset in the middle of an op.
    start_op("rst_mid", 2'b01, 32'h0000F00D, 32'h00000BEE);
    repeat (19) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_hi", hi_out, 0);
    chk("rst_mid_lo", lo_out, 0);
    chk("rst_mid_busy", busy_out, 0);
    chk("rst_mid_done", done_out, 0);
    chk("rst_mid_dbz", div_by_zero_out, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); #1; if (done_out) seen = 1; end
    chk("rst_mid_never_done", seen, 0);
    $display("reset at cycle 20 -> hi=%08h lo=%08h busy=%0b", hi_out, lo_out, busy_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
